// File: rtl/i2s_tx_multilane_serializer.sv
// -----------------------------------------------------------------------------
// i2s_tx_multilane_serializer
// Multi-lane I2S / left-justified transmit serializer. NUM_LANES data lanes
// share one SCLK/LRCLK pair derived from aud_mclk by a runtime divider. Stereo
// frames arrive through a one-deep holding register and are reloaded into the
// per-lane shift registers at every frame boundary. A missing frame at a
// boundary transmits silence and sets a sticky interrupt.
//
// Ports:
//   aud_mclk, aud_mrst   master clock, synchronous active-low reset
//   enable, mode         start/stop; 0 = I2S (1-bit delay), 1 = left-justified
//   sclk_div             SCLK half-period = sclk_div+1 mclk cycles
//   s_data_l/r, s_valid  stereo frame source, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_ready              holding register empty
//   irq_clr, irq         sticky underflow interrupt and its clear
//   busy                 FSM not idle
//   sclk_out, lrclk_out  bit clock and word select (0 = left)
//   sdata_out            serial data, bit k = lane k
//
// Handshake: a frame is transferred on any rising edge where s_valid && s_ready.
// s_ready is a pure function of registered state, so it never depends on
// s_valid within the same cycle; the source may hold s_valid and data until
// it sees the transfer.
// -----------------------------------------------------------------------------
module i2s_tx_multilane_serializer #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                            aud_mclk,
  input  logic                            aud_mrst,
  input  logic                            enable,
  input  logic                            mode,
  input  logic [7:0]                      sclk_div,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] s_data_l,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] s_data_r,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            irq_clr,
  output logic                            irq,
  output logic                            busy,
  output logic                            sclk_out,
  output logic                            lrclk_out,
  output logic [NUM_LANES-1:0]            sdata_out
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int BCW        = $clog2(FRAME_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);
  localparam logic [BCW-1:0] SLOT_BIT = BCW'(SLOT_WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]                      state;
  logic [7:0]                      div_q;
  logic [7:0]                      div_cnt;
  logic                            mode_q;
  logic                            sclk_q;
  logic                            stop_q;
  logic                            irq_q;
  logic                            hold_valid;
  logic [BCW-1:0]                  bit_cnt;
  logic [NUM_LANES*DATA_WIDTH-1:0] hold_l;
  logic [NUM_LANES*DATA_WIDTH-1:0] hold_r;
  logic [FRAME_BITS-1:0]           shift_q   [NUM_LANES];
  logic [FRAME_BITS-1:0]           frame_img [NUM_LANES];
  logic [NUM_LANES-1:0]            dly_q;

  logic sclk_tick, fall_edge, frame_end, stop_now, run_start, load_hold, underflow;

  assign sclk_tick = (state == ST_RUN) && (div_cnt == div_q);
  assign fall_edge = sclk_tick && sclk_q;
  assign frame_end = fall_edge && (bit_cnt == LAST_BIT);
  // A stop request seen anywhere in the frame takes effect only at its end.
  assign stop_now  = frame_end && (stop_q || !enable);
  assign run_start = (state == ST_WAIT) && enable && hold_valid;
  assign load_hold = run_start || (frame_end && !stop_now && hold_valid);
  assign underflow = frame_end && !stop_now && !hold_valid;

  // Per-lane frame image: left MSB-first, zero pad, right MSB-first, zero pad.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      frame_img[k] = '0;
      frame_img[k][FRAME_BITS-1 -: DATA_WIDTH] = hold_l[k*DATA_WIDTH +: DATA_WIDTH];
      frame_img[k][SLOT_WIDTH-1 -: DATA_WIDTH] = hold_r[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Control FSM, clock divider and bit counter.
  always_ff @(posedge aud_mclk) begin
    if (!aud_mrst) begin
      state   <= ST_IDLE;
      div_q   <= '0;
      mode_q  <= 1'b0;
      div_cnt <= '0;
      sclk_q  <= 1'b0;
      bit_cnt <= '0;
      stop_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            div_q  <= sclk_div;
            mode_q <= mode;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (hold_valid) begin
            state   <= ST_RUN;
            div_cnt <= '0;
            sclk_q  <= 1'b0;
            bit_cnt <= '0;
            stop_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!enable) stop_q <= 1'b1;
          if (sclk_tick) begin
            div_cnt <= '0;
            sclk_q  <= !sclk_q;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
          if (fall_edge) bit_cnt <= frame_end ? '0 : bit_cnt + BCW'(1);
          if (stop_now) begin
            state   <= ST_IDLE;
            sclk_q  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            stop_q  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Holding register. A load and a new transfer never coincide because a load
  // requires hold_valid, which holds s_ready low.
  always_ff @(posedge aud_mclk) begin
    if (!aud_mrst) begin
      hold_valid <= 1'b0;
      hold_l     <= '0;
      hold_r     <= '0;
    end else if (s_valid && s_ready) begin
      hold_valid <= 1'b1;
      hold_l     <= s_data_l;
      hold_r     <= s_data_r;
    end else if (load_hold) begin
      hold_valid <= 1'b0;
    end
  end

  // Shift registers and the I2S one-SCLK delay flops. The delay flop samples
  // the outgoing MSB on every falling edge, including the frame-end edge, so
  // slot bit 0 carries the last bit of the previous slot.
  always_ff @(posedge aud_mclk) begin
    if (!aud_mrst) begin
      for (int k = 0; k < NUM_LANES; k++) shift_q[k] <= '0;
      dly_q <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (fall_edge) dly_q[k] <= shift_q[k][FRAME_BITS-1];
        if (stop_now || underflow) begin
          shift_q[k] <= '0;
        end else if (load_hold) begin
          shift_q[k] <= frame_img[k];
        end else if (fall_edge) begin
          shift_q[k] <= {shift_q[k][FRAME_BITS-2:0], 1'b0};
        end
      end
      if (stop_now) dly_q <= '0;
    end
  end

  // Sticky underflow interrupt; a new underflow wins over a clear.
  always_ff @(posedge aud_mclk) begin
    if (!aud_mrst) begin
      irq_q <= 1'b0;
    end else if (underflow) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign s_ready   = !hold_valid;
  assign irq       = irq_q;
  assign busy      = (state != ST_IDLE);
  assign sclk_out  = (state == ST_RUN) && sclk_q;
  assign lrclk_out = (state == ST_RUN) && (bit_cnt >= SLOT_BIT);

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      sdata_out[k] = (state == ST_RUN) && (mode_q ? shift_q[k][FRAME_BITS-1] : dly_q[k]);
    end
  end

endmodule

// File: tb/tb_i2s_tx_multilane_serializer.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx_multilane_serializer
// Bench for i2s_tx_multilane_serializer (2 lanes, 24-bit samples, 32-bit slots).
// The reference model predicts every output from the elapsed mclk count since
// the first serial cycle, using plain arithmetic on the frame/bit position and
// the supplied sample values. A scenario table drives the main runs; hand
// sequences cover irq clearing and reset in mid-frame.
// -----------------------------------------------------------------------------
module tb_i2s_tx_multilane_serializer;

  localparam int NL = 2;
  localparam int DW = 24;
  localparam int SW = 32;
  localparam int FB = 2 * SW;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic [7:0]    sclk_div = 8'd0;
  logic [NL*DW-1:0] s_data_l = '0;
  logic [NL*DW-1:0] s_data_r = '0;
  logic          s_valid = 1'b0;
  logic          irq_clr = 1'b0;
  logic          s_ready, irq, busy, sclk_out, lrclk_out;
  logic [NL-1:0] sdata_out;

  always #5 clk = ~clk;

  i2s_tx_multilane_serializer #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .SLOT_WIDTH(SW)
  ) dut (
    .aud_mclk(clk), .aud_mrst(rst_n), .enable(enable), .mode(mode),
    .sclk_div(sclk_div), .s_data_l(s_data_l), .s_data_r(s_data_r),
    .s_valid(s_valid), .s_ready(s_ready), .irq_clr(irq_clr), .irq(irq),
    .busy(busy), .sclk_out(sclk_out), .lrclk_out(lrclk_out), .sdata_out(sdata_out)
  );

  int tests = 0;
  int fails = 0;
  int src_sent = 0;

  // frames offered to the DUT, in order
  logic [NL*DW-1:0] fr_l[$];
  logic [NL*DW-1:0] fr_r[$];

  typedef struct {
    logic       mode;
    logic [7:0] div;
    int         n_sup;
    int         n_frames;
    logic       irq_end;
    logic       ready_end;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; irq_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic make_frames(input int n, input logic fixed);
    logic [NL*DW-1:0] l, r;
    logic [DW-1:0]    smp;
    fr_l.delete(); fr_r.delete();
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < NL; k++) begin
        smp = DW'($urandom); l[k*DW +: DW] = smp;
        smp = DW'($urandom); r[k*DW +: DW] = smp;
      end
      if (fixed && f == 0) begin
        l[DW-1:0] = 24'hABCDEF;
        r[DW-1:0] = 24'h123456;
      end
      fr_l.push_back(l); fr_r.push_back(r);
    end
  endtask

  // Driver: offers fr_l/fr_r[0..n_sup-1] in order; called on a falling edge.
  task automatic source(input int n_sup, input int budget);
    int idx = 0;
    int guard = 0;
    while (idx < n_sup && guard < budget) begin
      s_valid = 1'b1; s_data_l = fr_l[idx]; s_data_r = fr_r[idx];
      if (s_ready) begin
        @(posedge clk);
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0;
    src_sent = idx;
  endtask

  // ---------------- reference model ----------------
  // Serial bit b (0 = first on the wire) of lane `lane` in frame f.
  function automatic logic stream_bit(input int f, input int lane, input int b, input int n_sup);
    logic [NL*DW-1:0] tmp;
    logic [DW-1:0]    smp;
    int               pos;
    if (f >= n_sup) return 1'b0;
    pos = (b < SW) ? b : b - SW;
    if (pos >= DW) return 1'b0;
    tmp = (b < SW) ? fr_l[f] : fr_r[f];
    smp = tmp[lane*DW +: DW];
    return smp[DW-1-pos];
  endfunction

  function automatic logic ready_model(input int c, input int n_sup, input int n_frames, input int frame_len);
    if (c < 0) return 1'b0;
    for (int j = 1; j < n_sup; j++)
      if (c >= (j-1)*frame_len + 1 && (j >= n_frames || c < j*frame_len)) return 1'b0;
    return 1'b1;
  endfunction

  // Returns {busy, s_ready, sclk, lrclk, irq, sdata} at c mclk cycles after
  // the first serial cycle.
  function automatic logic [NL+4:0] model_out(input int c, input int d, input logic m,
                                              input int n_sup, input int n_frames);
    int half = d + 1;
    int per = 2 * half;
    int frame_len = FB * per;
    int f, b;
    logic irq_e, rdy, sck, lr;
    logic [NL-1:0] sd;
    irq_e = (n_sup < n_frames) && (c >= n_sup * frame_len);
    rdy = ready_model(c, n_sup, n_frames, frame_len);
    if (c < 0) return {1'b1, rdy, 1'b0, 1'b0, 1'b0, {NL{1'b0}}};
    if (c >= n_frames * frame_len) return {1'b0, rdy, 1'b0, 1'b0, irq_e, {NL{1'b0}}};
    f = c / frame_len;
    b = (c / per) % FB;
    sck = ((c / half) % 2) == 1;
    lr = (b >= SW);
    for (int k = 0; k < NL; k++) begin
      if (m) sd[k] = stream_bit(f, k, b, n_sup);
      else if (b > 0) sd[k] = stream_bit(f, k, b - 1, n_sup);
      else sd[k] = (f == 0) ? 1'b0 : stream_bit(f - 1, k, FB - 1, n_sup);
    end
    return {1'b1, rdy, sck, lr, irq_e, sd};
  endfunction

  // Scoreboard for one run; starts on the falling edge where enable rose.
  task automatic check_run(input int id, input vec_t v);
    int d = int'(v.div);
    int frame_len = FB * 2 * (d + 1);
    int c_stop = (v.n_frames - 1) * frame_len + 10 * 2 * (d + 1);
    int last = v.n_frames * frame_len + 8;
    logic [NL+4:0] exp_v, act_v;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      exp_v = model_out(k - 2, d, v.mode, v.n_sup, v.n_frames);
      act_v = {busy, s_ready, sclk_out, lrclk_out, irq, sdata_out};
      check($sformatf("run%0d c=%0d {busy,rdy,sclk,lr,irq,sd}", id, k - 2), 32'(act_v), 32'(exp_v));
      if (k - 2 == c_stop) enable = 1'b0;
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    reset_dut();
    make_frames(v.n_sup, id < 2);
    mode = v.mode; sclk_div = v.div; enable = 1'b1;
    fork
      source(v.n_sup, v.n_frames * FB * 2 * (int'(v.div) + 1) + 100);
      check_run(id, v);
    join
    check($sformatf("run%0d frames sent", id), 32'(src_sent), 32'(v.n_sup));
    check($sformatf("run%0d irq at end", id), 32'(irq), 32'(v.irq_end));
    check($sformatf("run%0d s_ready at end", id), 32'(s_ready), 32'(v.ready_end));
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{mode: 1'b1, div: 8'd1, n_sup: 2, n_frames: 2, irq_end: 1'b0, ready_end: 1'b1};
    vecs[1] = '{mode: 1'b0, div: 8'd1, n_sup: 2, n_frames: 2, irq_end: 1'b0, ready_end: 1'b1};
    vecs[2] = '{mode: 1'b1, div: 8'd0, n_sup: 1, n_frames: 3, irq_end: 1'b1, ready_end: 1'b1};
    vecs[3] = '{mode: 1'b0, div: 8'd2, n_sup: 4, n_frames: 3, irq_end: 1'b0, ready_end: 1'b0};
    vecs[4] = '{mode: 1'b0, div: 8'd0, n_sup: 8, n_frames: 8, irq_end: 1'b0, ready_end: 1'b1};
    vecs[5] = '{mode: 1'b1, div: 8'd3, n_sup: 1, n_frames: 2, irq_end: 1'b1, ready_end: 1'b1};

    // reset state
    reset_dut();
    check("reset busy", 32'(busy), 32'd0);
    check("reset sclk", 32'(sclk_out), 32'd0);
    check("reset lrclk", 32'(lrclk_out), 32'd0);
    check("reset sdata", 32'(sdata_out), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    check("reset s_ready", 32'(s_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // randomized scenarios
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v.mode = 1'($urandom_range(0, 1));
      v.div = 8'($urandom_range(0, 3));
      v.n_frames = $urandom_range(1, 3);
      v.n_sup = $urandom_range(1, v.n_frames + 1);
      v.irq_end = (v.n_sup < v.n_frames);
      v.ready_end = !(v.n_sup > v.n_frames);
      run_vec(10 + i, v);
    end

    // irq clear, and clear coincident with a new underflow (LJ, div 0: frame = 128 mclk)
    reset_dut();
    make_frames(1, 1'b0);
    mode = 1'b1; sclk_div = 8'd0; enable = 1'b1;
    fork
      source(1, 50);
    join_none
    for (int k = 1; k <= 262; k++) begin
      @(negedge clk);
      case (k - 2)
        127: check("irq before underflow", 32'(irq), 32'd0);
        128: check("irq on underflow", 32'(irq), 32'd1);
        133: check("silence after underflow", 32'(sdata_out), 32'd0);
        200: irq_clr = 1'b1;
        201: begin irq_clr = 1'b0; check("irq after clear", 32'(irq), 32'd0); end
        255: irq_clr = 1'b1;
        256: begin irq_clr = 1'b0; check("irq set beats clear", 32'(irq), 32'd1); end
        257: check("irq held after collision", 32'(irq), 32'd1);
        default: ;
      endcase
    end

    // reset in mid-frame (LJ, div 1: frame = 256 mclk), then restart at div 3
    reset_dut();
    make_frames(1, 1'b0);
    mode = 1'b1; sclk_div = 8'd1; enable = 1'b1;
    fork
      source(1, 50);
    join_none
    for (int k = 1; k <= 420; k++) begin
      @(negedge clk);
      case (k - 2)
        256: check("midrst irq set", 32'(irq), 32'd1);
        300: begin
          check("midrst ready before fill", 32'(s_ready), 32'd1);
          s_valid = 1'b1; s_data_l = '1; s_data_r = '1;
        end
        301: begin s_valid = 1'b0; check("midrst ready after fill", 32'(s_ready), 32'd0); end
        417: begin
          check("midrst lrclk at bit 40", 32'(lrclk_out), 32'd1);
          rst_n = 1'b0; enable = 1'b0;
        end
        418: begin
          check("midrst outputs cleared", 32'({busy, sclk_out, lrclk_out, irq, sdata_out}), 32'd0);
          check("midrst s_ready", 32'(s_ready), 32'd1);
          rst_n = 1'b1;
        end
        default: ;
      endcase
    end
    // now on a falling edge with reset released: restart with sclk_div = 3
    make_frames(1, 1'b0);
    mode = 1'b1; sclk_div = 8'd3; enable = 1'b1;
    fork
      source(1, 50);
    join_none
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k >= 2) check($sformatf("div3 sclk c=%0d", k - 2), 32'(sclk_out), 32'(((k - 2) / 4) % 2));
    end
    reset_dut();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_tx_multilane_serializer.md
Name: i2s_tx_multilane_serializer

Overview:
- Parametrised next-generation I2S transmit serializer with NUM_LANES parallel data lanes sharing one SCLK/LRCLK pair.
- Derives SCLK and LRCLK from aud_mclk using a runtime divider.
- Supports I2S (one-bit delayed) and left-justified framing.
- Double-buffers stereo frames from a valid/ready source and raises a sticky underflow interrupt.
- Sits between the audio FIFO and the pads.

Parameters:
NUM_LANES, 4, number of sdata lanes (1..8)
DATA_WIDTH, 24, sample bits per channel (8..32)
SLOT_WIDTH, 32, SCLK cycles per channel slot (>= DATA_WIDTH, <= 32)

Ports:
aud_mclk  in  1  master audio clock; sole clock
aud_mrst  in  1  synchronous active-low reset
enable  in  1  start/stop transmission
mode  in  1  0 = I2S (1-bit delay), 1 = left-justified
sclk_div  in  8  SCLK half-period = sclk_div+1 mclk cycles
s_data_l  in  NUM_LANES*DATA_WIDTH  left samples; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
s_data_r  in  NUM_LANES*DATA_WIDTH  right samples, same packing
s_valid  in  1  frame valid
s_ready  out  1  holding register empty
irq_clr  in  1  single-cycle clear of irq
irq  out  1  sticky underflow interrupt
busy  out  1  state != IDLE
sclk_out  out  1  serial bit clock
lrclk_out  out  1  word select; 0 = left
sdata_out  out  NUM_LANES  serial data, bit k = lane k

Behaviour:
- Reset (aud_mrst == 0 at a rising edge of aud_mclk):
  - sclk_out, lrclk_out, sdata_out, irq and busy all clear to 0.
  - s_ready = 1; state = IDLE; holding and shift registers cleared.
  - Reset mid-frame takes effect the next cycle; the frame is not completed.
- Holding register:
  - Transfer on s_valid && s_ready; captures s_data_l/s_data_r.
  - s_ready = !hold_valid.
  - hold_valid clears in the cycle the active registers load from it; s_ready is 1 the following cycle.
- FSM:
  - IDLE: outputs low. enable == 1 latches sclk_div and mode, then goes to WAIT.
  - WAIT: sclk_out and lrclk_out held 0. Goes to RUN when hold_valid. The load happens on this transition, so no underflow is reported at start-up. enable == 0 returns to IDLE.
  - RUN: serializes continuously. If enable == 0 is sampled at any point, the current frame completes through its last bit, then the FSM goes to IDLE. No new load occurs at that boundary.
  - sclk_div and mode are ignored outside IDLE.
- Clocking:
  - div_cnt counts 0..sclk_div; sclk_out toggles when div_cnt == sclk_div, then div_cnt wraps to 0.
  - On RUN entry, sclk_out = 0 with div_cnt = 0.
  - SCLK period = 2*(sclk_div+1) mclk cycles. sclk_div = 0 gives mclk/2.
- Framing:
  - bit_cnt runs 0..2*SLOT_WIDTH-1 and advances on each sclk_out falling edge (the cycle sclk_out goes 1→0). All data and lrclk changes coincide with the falling edge.
  - lrclk_out = (bit_cnt >= SLOT_WIDTH).
  - Per-lane 2*SLOT_WIDTH shift register layout: left sample MSB-first, zero pad to SLOT_WIDTH, right sample MSB-first, zero pad.
  - Left-justified mode: sdata_out[k] = shift MSB.
  - I2S mode: sdata_out[k] = shift MSB delayed by one SCLK through a per-lane flop. Bit 0 of each slot carries the last bit of the previous slot (pad zero, or the sample LSB when SLOT_WIDTH == DATA_WIDTH). The flop is 0 after reset/IDLE.
  - Frame boundary: the falling edge where bit_cnt wraps 2*SLOT_WIDTH-1 → 0. The shift registers load from the holding register.
- Underflow:
  - At a frame boundary with hold_valid == 0 and enable == 1, the shift registers load zeros and irq is set to 1. Transmission continues with silence.
  - irq stays set until irq_clr. irq_clr and a new underflow in the same cycle: irq = 1 (set wins).
- Width rule: sample bits are never truncated. Pad bits are always 0.

Test Plan:
- LJ mode, NUM_LANES=2, DATA_WIDTH=24, SLOT_WIDTH=32, sclk_div=1, lane0 L=0xABCDEF, R=0x123456 -> SCLK period 4 mclk. lrclk low 32 SCLK, then high 32. lane0 shows 0xABCDEF MSB-first, 8 zeros, 0x123456, 8 zeros. lane1 carries its own data independently.
- Same frame in I2S mode -> lrclk falls at bit_cnt 0. Left MSB (1) appears one SCLK after the lrclk falling edge. First bit of the slot = 0 (pad).
- Supply one frame only, enable held -> second frame is all zeros. irq=1 at that frame boundary. irq_clr pulse -> irq=0. irq_clr coincident with the next underflow -> irq stays 1.
- Back-to-back valid frames -> s_ready=0 after the first hold fill, and returns to 1 one cycle after each boundary load. No underflow, irq stays 0 across 8 frames.
- enable dropped at bit_cnt=10 -> frame completes through bit_cnt 63, then busy=0, sclk_out=0, lrclk_out=0 and sdata_out=0. A held frame stays in the holding register.
- aud_mrst=0 at bit_cnt=40 -> next cycle all outputs 0, s_ready=1, irq=0. Re-enable with sclk_div=3 -> SCLK period 8 mclk.
